// File: rtl/elm_pkg.sv
// Shared defaults and FSM state encoding for the ELM argmax tracker.
// Imported by the tracker top and its compare cell.
package elm_pkg;

    localparam int ELM_DATA_W      = 32;
    localparam int ELM_IDX_W       = 4;
    localparam int ELM_NUM_CLASSES = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } elm_state_t;

endpackage

// File: rtl/elm_max_cmp.sv
// Combinational max-compare cell: strict unsigned candidate > current.
// larger follows current on ties, so earlier winners are kept.
module elm_max_cmp
    import elm_pkg::*;
#(
    parameter int DATA_W = ELM_DATA_W
) (
    input  logic [DATA_W-1:0] candidate,
    input  logic [DATA_W-1:0] current,
    output logic [DATA_W-1:0] larger,
    output logic              gt
);

    assign gt     = (candidate > current);
    assign larger = gt ? candidate : current;

endmodule

// File: rtl/elm_argmax_tracker.sv
// Streams NUM_CLASSES unsigned scores per frame and reports the maximum
// score and its arrival index through a valid/ready result handshake.
module elm_argmax_tracker
    import elm_pkg::*;
#(
    parameter int DATA_W      = ELM_DATA_W,
    parameter int NUM_CLASSES = ELM_NUM_CLASSES,
    parameter int IDX_W       = ELM_IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] max_value,
    output logic [IDX_W-1:0]  max_index,
    output logic              busy
);

    // One extra bit so a full 2**IDX_W frame never wraps the counter.
    localparam int              CNT_W    = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CLASSES - 1);

    elm_state_t         state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [DATA_W-1:0]  max_value_reg;
    logic [IDX_W-1:0]   max_index_reg;

    logic [DATA_W-1:0]  cmp_larger;
    logic               cmp_gt;
    logic               beat_accept;
    logic               first_beat;

    elm_max_cmp #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .candidate (in_data),
        .current   (max_value_reg),
        .larger    (cmp_larger),
        .gt        (cmp_gt)
    );

    assign beat_accept = (state_reg == COLLECT) && in_valid;
    assign first_beat  = (cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            max_value_reg <= '0;
            max_index_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= COLLECT;
                        cnt_reg   <= '0;
                    end
                end
                COLLECT: begin
                    if (beat_accept) begin
                        // Beat 0 seeds the running max regardless of stale contents.
                        if (first_beat) begin
                            max_value_reg <= in_data;
                            max_index_reg <= '0;
                        end else begin
                            max_value_reg <= cmp_larger;
                            if (cmp_gt) begin
                                max_index_reg <= cnt_reg[IDX_W-1:0];
                            end
                        end
                        if (cnt_reg == LAST_CNT) begin
                            state_reg <= DONE;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (start) begin
                            state_reg <= COLLECT;
                            cnt_reg   <= '0;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == COLLECT);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == COLLECT) || (state_reg == DONE);
    assign max_value = max_value_reg;
    assign max_index = max_index_reg;

endmodule

// File: tb/tb_elm_argmax_tracker.sv
// Directed bench for elm_argmax_tracker: inputs change and outputs are
// sampled on the falling edge, so the DUT acts on each rising edge.
module tb_elm_argmax_tracker;

    localparam int DATA_W = 32;
    localparam int NC     = 10;
    localparam int IDX_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] max_value;
    logic [IDX_W-1:0]  max_index;
    logic              busy;

    int checks;
    int errors;

    logic [DATA_W-1:0] sc [NC];

    elm_argmax_tracker #(
        .DATA_W      (DATA_W),
        .NUM_CLASSES (NC),
        .IDX_W       (IDX_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .max_value (max_value),
        .max_index (max_index),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start in IDLE; returns on the negedge after COLLECT is entered.
    task automatic start_frame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Feeds sc[0..NC-1]; optional idle gap before every beat after the first,
    // optional start pulse alongside beat start_at. Ends one negedge after
    // the last beat is accepted.
    task automatic feed_beats(input bit gaps, input int start_at);
        for (int i = 0; i < NC; i++) begin
            if (gaps && i > 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL in_ready_beat%0d: got %b expected 1", i, in_ready);
            end
            if (i == NC - 1) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL early_out_valid: got %b expected 0", out_valid);
                end
            end
            in_valid = 1'b1;
            in_data  = sc[i];
            start    = (i == start_at);
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL release_idle: out_valid=%b busy=%b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
            max_value !== '0 || max_index !== '0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b max_value=%h max_index=%0d expected all 0",
                     in_ready, out_valid, busy, max_value, max_index);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: outputs idle");
    endtask

    task automatic test_basic_tie();
        sc = '{32'd5, 32'd9, 32'd3, 32'd9, 32'd1, 32'd0, 32'd7, 32'd2, 32'd8, 32'd4};
        start_frame();
        feed_beats(1'b0, -1);
        checks++;
        if (out_valid !== 1'b1 || max_value !== 32'd9 || max_index !== 4'd1) begin
            errors++;
            $display("FAIL basic_tie: out_valid=%b value=%0d index=%0d expected 1 9 1",
                     out_valid, max_value, max_index);
        end
        $display("frame basic_tie: value=%0d index=%0d", max_value, max_index);
        release_result();
    endtask

    task automatic test_descending();
        for (int i = 0; i < NC; i++) sc[i] = DATA_W'(100 - 10 * i);
        start_frame();
        feed_beats(1'b0, -1);
        checks++;
        if (out_valid !== 1'b1 || max_value !== 32'd100 || max_index !== 4'd0) begin
            errors++;
            $display("FAIL descending: out_valid=%b value=%0d index=%0d expected 1 100 0",
                     out_valid, max_value, max_index);
        end
        $display("frame descending: value=%0d index=%0d", max_value, max_index);
        release_result();
    endtask

    task automatic test_all_equal();
        for (int i = 0; i < NC; i++) sc[i] = 32'hFFFF_FFFF;
        start_frame();
        feed_beats(1'b0, -1);
        checks++;
        if (out_valid !== 1'b1 || max_value !== 32'hFFFF_FFFF || max_index !== 4'd0) begin
            errors++;
            $display("FAIL all_equal: out_valid=%b value=%h index=%0d expected 1 ffffffff 0",
                     out_valid, max_value, max_index);
        end
        $display("frame all_equal: value=%h index=%0d", max_value, max_index);
        release_result();
    endtask

    task automatic test_unsigned_gaps();
        for (int i = 0; i < NC; i++) sc[i] = 32'h7FFF_FFFF;
        sc[7] = 32'h8000_0000;
        start_frame();
        feed_beats(1'b1, -1);
        checks++;
        if (out_valid !== 1'b1 || max_value !== 32'h8000_0000 || max_index !== 4'd7) begin
            errors++;
            $display("FAIL unsigned_gaps: out_valid=%b value=%h index=%0d expected 1 80000000 7",
                     out_valid, max_value, max_index);
        end
        $display("frame unsigned_gaps: value=%h index=%0d", max_value, max_index);
        release_result();
    endtask

    task automatic test_back_to_back();
        sc = '{32'd5, 32'd9, 32'd3, 32'd9, 32'd1, 32'd0, 32'd7, 32'd2, 32'd8, 32'd4};
        start_frame();
        feed_beats(1'b0, -1);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
                max_value !== 32'd9 || max_index !== 4'd1) begin
                errors++;
                $display("FAIL backpressure_c%0d: out_valid=%b in_ready=%b busy=%b value=%0d index=%0d expected 1 0 1 9 1",
                         c, out_valid, in_ready, busy, max_value, max_index);
            end
            @(negedge clk);
        end
        $display("frame held: value=%0d index=%0d", max_value, max_index);
        out_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        for (int i = 0; i < NC; i++) sc[i] = DATA_W'(5 * (i + 1));
        feed_beats(1'b0, -1);
        checks++;
        if (out_valid !== 1'b1 || max_value !== 32'd50 || max_index !== 4'd9) begin
            errors++;
            $display("FAIL back_to_back: out_valid=%b value=%0d index=%0d expected 1 50 9",
                     out_valid, max_value, max_index);
        end
        $display("frame back_to_back: value=%0d index=%0d", max_value, max_index);
        release_result();
    endtask

    task automatic test_reset_mid_frame();
        start_frame();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(200 + 100 * i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
            max_value !== '0 || max_index !== '0) begin
            errors++;
            $display("FAIL mid_reset: in_ready=%b out_valid=%b busy=%b value=%0d index=%0d expected all 0",
                     in_ready, out_valid, busy, max_value, max_index);
        end
        rst_n = 1'b1;
        @(negedge clk);
        sc = '{32'd10, 32'd20, 32'd30, 32'd77, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd1};
        start_frame();
        feed_beats(1'b0, -1);
        checks++;
        if (out_valid !== 1'b1 || max_value !== 32'd77 || max_index !== 4'd3) begin
            errors++;
            $display("FAIL after_mid_reset: out_valid=%b value=%0d index=%0d expected 1 77 3",
                     out_valid, max_value, max_index);
        end
        $display("frame after_mid_reset: value=%0d index=%0d", max_value, max_index);
        release_result();
    endtask

    task automatic test_start_in_collect();
        sc = '{32'd3, 32'd1, 32'd4, 32'd1, 32'd5, 32'd9, 32'd2, 32'd6, 32'd5, 32'd3};
        start_frame();
        feed_beats(1'b0, 5);
        checks++;
        if (out_valid !== 1'b1 || max_value !== 32'd9 || max_index !== 4'd5) begin
            errors++;
            $display("FAIL start_in_collect: out_valid=%b value=%0d index=%0d expected 1 9 5",
                     out_valid, max_value, max_index);
        end
        $display("frame start_in_collect: value=%0d index=%0d", max_value, max_index);
        release_result();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic_tie();
        test_descending();
        test_all_equal();
        test_unsigned_gaps();
        test_back_to_back();
        test_reset_mid_frame();
        test_start_in_collect();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/elm_argmax_tracker.md
Name: elm_argmax_tracker

Overview:
- Sequential classifier back-end for the ELM output layer.
- Consumes a stream of NUM_CLASSES unsigned output-neuron scores, one per accepted beat, and tracks the running maximum and its index.
- Presents the winning class index and score through a valid/ready handshake.
- Sits directly downstream of the output-layer accumulator and uses a combinational max-compare cell for each update.

Parameters:
- DATA_W, 32, score width; scores are compared as unsigned.
- NUM_CLASSES, 10, scores per frame; legal range 2..2**IDX_W.
- IDX_W, 4, class index width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begins a new frame; sampled only in IDLE, or in DONE together with out_ready.
- in_valid  in  1  score beat valid.
- in_ready  out  1  block accepts a beat; high only in COLLECT.
- in_data  in  DATA_W  neuron score.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- max_value  out  DATA_W  maximum score of the frame.
- max_index  out  IDX_W  class index of that maximum, 0-based in arrival order.
- busy  out  1  high in COLLECT or DONE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state returns to IDLE; the beat counter clears.
  - in_ready=0, out_valid=0, busy=0, max_value=0, max_index=0.
  - Reset mid-frame discards the partial frame with no output.
- States:
  - IDLE: on start=1, go to COLLECT and clear the counter. max_value and max_index hold their old values until the first beat.
  - COLLECT: in_ready=1. A beat is accepted when in_valid && in_ready.
    - Beat 0: unconditionally load max_value=in_data and max_index=0.
    - Beat k>0: if in_data > max_value (strict, unsigned), load in_data and index k; otherwise hold.
    - After the beat with counter==NUM_CLASSES-1 is accepted, go to DONE.
    - start is ignored while in COLLECT.
  - DONE: out_valid=1 and in_ready=0. max_value and max_index stay stable while out_valid=1 && out_ready=0.
    - On out_ready=1 without start: go to IDLE.
    - On out_ready=1 with start=1: go directly to COLLECT (back-to-back frame) and clear the counter.
- Ties: strict compare, so the lowest index holding the maximum wins. All-equal scores give index 0.
- Latency: out_valid rises on the clk edge after the clock that accepts the last beat. In-to-out latency is 1 cycle. Frame throughput is NUM_CLASSES + 1 cycles with continuous in_valid and out_ready.
- in_valid gaps: the counter and running max hold.
- The counter is IDX_W+1 bits wide, so it cannot wrap when NUM_CLASSES = 2**IDX_W. It resets to 0 on each frame start.
- Extremes: scores 0 and 2**DATA_W-1 are handled; no overflow is possible because the block only compares.

Decomposition:
- Shared package elm_pkg holds DATA_W, IDX_W, NUM_CLASSES defaults and the state encoding (IDLE=2'd0, COLLECT=2'd1, DONE=2'd2).
- One sub-module is natural: elm_max_cmp, a combinational cell.
  - Inputs: candidate and current.
  - Outputs: the larger value plus a gt flag (strict unsigned candidate>current).
  - The tracker uses gt to gate the max_value/max_index update.

Test Plan:
- Reset behaviour: reset, then start and scores 5,9,3,9,1,0,7,2,8,4 with continuous valid -> out_valid 1 cycle after beat 9; max_value=9, max_index=1 (tie keeps the earlier index).
- Descending and all-equal frames:
  - Scores 100,90,...,10 -> max_index=0, max_value=100.
  - All scores 32'hFFFF_FFFF -> max_index=0, max_value=32'hFFFF_FFFF.
- Unsigned compare and gaps: scores with beat 7 = 32'h8000_0000 and the others 32'h7FFF_FFFF, with in_valid toggling every other cycle -> max_index=7, max_value=32'h8000_0000. Counter holds during gaps.
- Backpressure and back-to-back: out_ready held 0 for 5 cycles -> outputs stable, in_ready=0. Then out_ready=1 with start=1 -> next frame (max at index 9, value 50) accepted immediately. Result max_index=9.
- Reset mid-frame: rst_n=0 after 4 beats -> all outputs 0 and IDLE. The next full frame with max 77 at index 3 -> max_index=3 and no residue from the aborted frame.
- start during COLLECT: pulse start at beat 5 -> ignored. Frame completes after 10 beats with the correct result.
